// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the round-robin arbiter family: client count, index
// width, FSM state type and the rotate/find-first/unrotate priority search.
package rr_arbiter_4_pkg;

    localparam int NUM_CLIENTS = 4;
    localparam int IDX_W       = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Search order starts one past 'last' and wraps, so 'last' itself is tried last.
    function automatic pick_t rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                      input logic [IDX_W-1:0]       last);
        logic [NUM_CLIENTS-1:0] rot;
        pick_t                  res;
        res = '0;
        rot = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            rot[k] = req[last + IDX_W'(k + 1)];
        end
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                res.found = 1'b1;
                res.idx   = last + IDX_W'(k + 1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_decoder.sv
// 2-to-4 one-hot decoder with enable; output is all zero when disabled.
module decoder_2x4 (
    input  logic [1:0] idx,
    input  logic       en,
    output logic [3:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign y[gi] = en && (idx == 2'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-client round-robin arbiter with grant hold and bounded tenure.
// All outputs are registered; the one-hot grant comes from decoder_2x4.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] req,
    output logic [NUM_CLIENTS-1:0] gnt,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   gnt_valid,
    output logic                   preempt
);

    localparam int              HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t             state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [IDX_W-1:0]       last_reg, last_next;
    logic [HOLD_W-1:0]      hold_reg, hold_next;
    logic                   preempt_reg, preempt_next;
    logic [NUM_CLIENTS-1:0] gnt_reg, gnt_next;
    logic                   valid_reg;

    logic [NUM_CLIENTS-1:0] req_clean;
    logic [NUM_CLIENTS-1:0] req_others;
    logic                   owner_req;
    pick_t                  pick_all, pick_others;

    // Only a definite 1 counts as a request, so X/Z never reaches the grant.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_req_clean
            assign req_clean[gi] = (req[gi] === 1'b1);
        end
    endgenerate

    assign owner_req   = |(req_clean & gnt_reg);
    assign req_others  = req_clean & ~gnt_reg;
    assign pick_all    = rr_pick(req_clean, last_reg);
    assign pick_others = rr_pick(req_others, last_reg);

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        last_next    = last_reg;
        hold_next    = hold_reg;
        preempt_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_all.found) begin
                    state_next = OWNED;
                    idx_next   = pick_all.idx;
                    last_next  = pick_all.idx;
                    hold_next  = '0;
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    // Release wins over a coincident timeout, hence no preempt here.
                    hold_next = '0;
                    if (pick_others.found) begin
                        idx_next  = pick_others.idx;
                        last_next = pick_others.idx;
                    end else begin
                        state_next = IDLE;
                    end
                end else if ((hold_reg == HOLD_LAST) && pick_others.found) begin
                    idx_next     = pick_others.idx;
                    last_next    = pick_others.idx;
                    hold_next    = '0;
                    preempt_next = 1'b1;
                end else if (hold_reg != HOLD_LAST) begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                hold_next  = '0;
            end
        endcase
    end

    decoder_2x4 u_dec (
        .idx (idx_next),
        .en  (state_next == OWNED),
        .y   (gnt_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            last_reg    <= IDX_W'(NUM_CLIENTS - 1);
            hold_reg    <= '0;
            preempt_reg <= 1'b0;
            gnt_reg     <= '0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            last_reg    <= last_next;
            hold_reg    <= hold_next;
            preempt_reg <= preempt_next;
            gnt_reg     <= gnt_next;
            valid_reg   <= (state_next == OWNED);
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_idx   = idx_reg;
    assign gnt_valid = valid_reg;
    assign preempt   = preempt_reg;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Randomised and directed scoreboard bench for rr_arbiter_4 against a
// queue-based behavioural model of the round-robin tenure rules.
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       pre;
        int         txn;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn_cnt  = 0;

    // Reference model: owner (-1 when idle), last owner, cycles held so far.
    int m_owner;
    int m_last;
    int m_held;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic int find_next(bit [3:0] a, int from);
        for (int k = 1; k <= 4; k++) begin
            if (a[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_last  = 3;
        m_held  = 0;
    endfunction

    function automatic exp_t model_step(logic [3:0] r);
        bit [3:0] a;
        bit [3:0] others;
        int       nxt;
        exp_t     e;
        for (int i = 0; i < 4; i++) a[i] = (r[i] === 1'b1);
        e.pre = 1'b0;
        nxt   = m_owner;
        if (m_owner < 0) begin
            nxt = find_next(a, m_last);
        end else begin
            others = a & ~(4'b0001 << m_owner);
            if (!a[m_owner]) begin
                nxt = find_next(others, m_last);
            end else if (m_held >= MAX_HOLD && others != 0) begin
                nxt   = find_next(others, m_last);
                e.pre = 1'b1;
            end
        end
        if (nxt != m_owner) begin
            m_owner = nxt;
            m_held  = 1;
            if (nxt >= 0) m_last = nxt;
        end else if (m_owner >= 0) begin
            m_held++;
        end
        e.valid = (m_owner >= 0);
        e.gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.idx   = 2'(m_last);
        e.txn   = txn_cnt;
        return e;
    endfunction

    // Monitor: one expected response is compared per cycle, on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("gnt", 32'(gnt), 32'(e.gnt));
            check("gnt_valid", 32'(gnt_valid), 32'(e.valid));
            check("preempt", 32'(preempt), 32'(e.pre));
            check("gnt_known", 32'($isunknown({gnt, gnt_idx, gnt_valid, preempt})), 32'd0);
            if (e.valid) check("gnt_idx", 32'(gnt_idx), 32'(e.idx));
            $display("txn %0d req=%b gnt=%b idx=%0d valid=%b preempt=%b exp_gnt=%b exp_pre=%b",
                     e.txn, req, gnt, gnt_idx, gnt_valid, preempt, e.gnt, e.pre);
        end
    end

    // Drive one request pattern across one rising edge and queue its expectation.
    task automatic cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        txn_cnt++;
        exp_q.push_back(model_step(r));
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_idx", 32'(gnt_idx), 32'd0);
        check("rst_valid", 32'(gnt_valid), 32'd0);
        check("rst_preempt", 32'(preempt), 32'd0);
        $display("reset asserted at %0t gnt=%b valid=%b", $time, gnt, gnt_valid);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic [3:0] x_req;
        int         len;
        model_reset();
        rst = 1'b1;
        #12;
        check("por_gnt", 32'(gnt), 32'd0);
        check("por_valid", 32'(gnt_valid), 32'd0);
        rst = 1'b0;

        // Full contention: tenure hops 0->1->2->3->0 with preempt pulses.
        for (int i = 0; i < 40; i++) cycle(4'b1111);
        cycle(4'b0000);

        // Lone requester keeps the grant indefinitely.
        for (int i = 0; i < 20; i++) cycle(4'b0100);
        cycle(4'b0000);

        // Owner 1 releases while client 3 waits: handover without bubble.
        for (int i = 0; i < 3; i++) cycle(4'b0010);
        cycle(4'b1000);
        cycle(4'b0000);

        // Release coinciding with tenure expiry is treated as a release.
        for (int i = 0; i < 10; i++) cycle(4'b0010);
        cycle(4'b0100);
        cycle(4'b0000);

        // Reset mid-grant then priority restarts from client 0.
        for (int i = 0; i < 3; i++) cycle(4'b0010);
        do_reset();
        cycle(4'b1010);
        cycle(4'b1010);

        // Unknown request bits are not requests.
        do_reset();
        x_req = 4'b00x1;
        cycle(x_req);
        cycle(4'b0000);

        // Random bursts with occasional resets.
        for (int i = 0; i < 120; i++) begin
            r   = 4'($urandom);
            len = $urandom_range(1, 14);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
                cycle(r);
            end
            if ($urandom_range(0, 30) == 0) do_reset();
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter with grant hold and bounded tenure. It shares one downstream resource between four clients: it picks one active requester, presents a registered one-hot grant plus its 2-bit index, and holds the grant until the owner releases or its tenure expires. Its one-hot grant is produced by the team's 2-to-4 decoder, so the grant encoding matches that decoder exactly.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles one owner keeps the grant while another requester waits; legal range 2..256.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-client request, level-sensitive; bit i = client i.
- gnt  output  4  registered one-hot grant; 4'b0000 when idle.
- gnt_idx  output  2  index of the current owner; valid only when gnt_valid=1.
- gnt_valid  output  1  high while any grant is held.
- preempt  output  1  one-cycle pulse on the cycle the grant moves because of tenure expiry.

## Operation
- States: IDLE (no owner) and OWNED (gnt_valid=1).
- Round-robin pointer `last` (2 bits) holds the index of the most recent owner. The search order is last+1, last+2, last+3, last, modulo 4, with wrap 3->0.
- IDLE: if req != 0, take the first set bit in search order, move to OWNED, set gnt_idx, set gnt = decode(gnt_idx), clear hold_cnt.
- OWNED, owner req low (release):
  - If another req is set, hand over to the next client in search order from the releasing owner, with no bubble cycle.
  - Otherwise go to IDLE with gnt=0.
- OWNED, owner req high:
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - If hold_cnt==MAX_HOLD-1 and any other req bit is set, grant moves to the next other requester in search order and preempt=1 for that cycle.
  - If no other requester is active, the owner keeps the grant indefinitely.
- On every grant change: `last` updates to the new owner and hold_cnt resets to 0.
- A preempted owner that still requests is served again in normal rotation. There is no immediate re-grant.
- gnt is always one-hot or zero. gnt_valid equals |gnt.
- req bits that are X or Z are treated as not requesting. An X or Z on req never propagates to gnt.

## Timing
- Reset (async, immediate): gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, preempt=0, last=2'b11 (so client 0 has first priority), hold_cnt=0, state IDLE.
- Latency: req sampled at edge N gives gnt valid after edge N (1 cycle). Release sampled at edge N removes or moves the grant at edge N.
- hold_cnt width is clog2(MAX_HOLD). The owner holds at most MAX_HOLD cycles while contended.
- Simultaneous release and timeout: treat as release, with preempt=0.
- Reset asserted mid-tenure: grant drops asynchronously. After reset deasserts, arbitration restarts from client 0 priority on the first edge.
- All outputs are registered. There are no combinational paths from req to outputs.

## Structure
- Shared package: client count constant (4), index width (2), and the state enum {IDLE, OWNED}.
- Sub-module: instantiate decoder_2x4 to convert the next-owner index to one-hot. Register its output into gnt.
- A priority-search function (rotate, find-first, unrotate) lives in the package for reuse by later 8-client variants.

## Test plan
- Reset then req=4'b1111 held: gnt steps 0001 (8 cycles) -> 0010 -> 0100 -> 1000 -> 0001. Each hop is after MAX_HOLD=8 cycles, with preempt pulsing at each hop.
- req=4'b0100 alone for 20 cycles: gnt=0100 after 1 cycle, held for all 20 cycles, preempt never asserts.
- Owner 1 drops req while req[3] is set: on the next edge gnt=1000 with no zero cycle and preempt=0.
- Release and timeout on the same edge (owner drops req at hold_cnt=7, req[2] set): gnt=0100, preempt=0.
- rst pulsed mid-grant (gnt=0010): outputs go to zero without a clock edge. After release with req=4'b1010, first grant is 0010 (index 1, since search starts at 0).
- req=4'b00x1 from idle: gnt=0001, with no X on gnt or gnt_idx. Then req=4'b0000 gives gnt=0000 and gnt_valid=0 on the next edge.
